mfcc_dct_sequencer: RTL and testbench
=====================================

# mfcc_dct_sequencer

Sequencer for the time-multiplexed MFCC DCT datapath: one MAC, one cosine ROM and one 13-entry result register file. It accepts one log-mel frame per handshake and steps the MAC through all N_OUTPUTS × N_INPUTS products, one per cycle. It writes each finished coefficient into the result file and holds a frame-done handshake until the classifier consumes the frame. It sits between the log-energy stage and the emotion classifier and replaces the single-cycle `start`/`done` DCT.

## Interface
- N_INPUTS, 40: log-mel bins per frame (terms per coefficient)
- N_OUTPUTS, 13: cepstral coefficients per frame
- SEL_W, $clog2(N_INPUTS) = 6: input-select width
- ADDR_W, $clog2(N_INPUTS*N_OUTPUTS) = 10: ROM address width
- OADDR_W, $clog2(N_OUTPUTS) = 4: result address width
- CNT_W, 16: frame counter width

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream frame available
- in_ready  out  1  sequencer can accept a frame
- frame_load  out  1  one-cycle strobe; datapath captures the input frame
- mac_sel  out  SEL_W  input bin index j for the current term
- rom_addr  out  ADDR_W  cosine ROM address, i*N_INPUTS + j
- acc_en  out  1  accumulate the current product
- acc_clr  out  1  with acc_en, the accumulator restarts at 0 plus the product
- out_wr_en  out  1  write acc_q into the result file
- out_wr_addr  out  OADDR_W  coefficient index being written
- out_valid  out  1  all N_OUTPUTS coefficients written
- out_ready  in  1  downstream consumed the frame
- busy  out  1  state ≠ IDLE
- frames_done  out  CNT_W  completed-frame count, wraps at 2^CNT_W

## Operation
- States: IDLE, LOAD, RUN, FLUSH, DONE.
- IDLE: in_ready=1. If in_valid is high, go to LOAD.
- LOAD: frame_load=1 for exactly one cycle. Clear i, j and rom_addr to 0. Go to RUN.
- RUN: acc_en=1 every cycle, with mac_sel=j and rom_addr=i*N_INPUTS+j.
  - acc_clr=1 when j==0.
  - j increments each cycle and wraps to 0 after N_INPUTS-1; i increments on that wrap.
  - rom_addr is a running counter that increments by 1 every RUN cycle; no multiplier.
  - After term (i, N_INPUTS-1), go to FLUSH if i==N_OUTPUTS-1. Otherwise stay in RUN.
- Result write: in the cycle after the last term of coefficient i, out_wr_en=1 and out_wr_addr=i.
  - This write overlaps term (i+1, 0), which carries acc_clr. The datapath samples acc_q on the same edge the accumulator restarts, so there is no bubble.
- FLUSH: write the final coefficient (out_wr_addr=N_OUTPUTS-1). acc_en=0. Go to DONE.
- DONE: out_valid=1 and frames_done increments on entry. If out_ready is high, go to IDLE.
- Arithmetic is fixed in the datapath: Q1.9 coefficients, 18-bit accumulator. The sequencer has no data path.
- acc_en, acc_clr, out_wr_en and frame_load are 0 in every state not listed for them.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, busy=0
  - frame_load, acc_en, acc_clr, out_wr_en, out_valid all 0
  - mac_sel, rom_addr, out_wr_addr, frames_done all 0
- All outputs are registered or decoded directly from state and counter registers. None depends combinationally on in_valid or out_ready.
- Cycle numbering: cycle 0 is the in_valid&&in_ready edge.
  - LOAD: cycle 1.
  - RUN: cycles 2 to 2+N_OUTPUTS*N_INPUTS-1 (2 to 521 at defaults).
  - Write of coefficient k: cycle 2+(k+1)*N_INPUTS.
  - FLUSH: cycle 522.
  - out_valid first high: cycle 523. Frame latency is 523 cycles.
- Minimum frame period is 524 cycles, with out_ready held high.
- Handshakes:
  - in_valid is ignored outside IDLE. A frame is accepted at the earliest on the cycle after DONE exits.
  - out_valid holds until out_ready is sampled high, and drops on the next cycle.
  - out_ready is ignored outside DONE.
- rst_n low in any state forces the reset values immediately, with no clock needed.
  - A partial frame is discarded: no out_wr_en and no out_valid for it.
  - frames_done is cleared.
- frames_done wraps from 0xFFFF to 0.

## Test plan
- Reset: hold rst_n low for 3 cycles, then release → all outputs at their reset values and in_ready=1. Assert rst_n low asynchronously mid-cycle → outputs clear without waiting for a clock edge.
- Single frame, out_ready high, datapath model with all inputs 1 and the real ROM →
  - frame_load at cycle 1;
  - exactly 520 acc_en cycles, with acc_clr at rom_addr 0, 40, …, 480;
  - 13 writes at cycles 42, 82, …, 522 with addresses 0..12;
  - out_valid at cycle 523;
  - result file equals golden row sums of the ROM.
- Back-pressure: hold out_ready low for 50 cycles → out_valid stays high, in_ready stays 0 and in_valid is ignored. Raise out_ready → IDLE next cycle, frames_done=1.
- Back-to-back: in_valid tied high for 3 frames → accepts at cycles 0, 524 and 1048. frames_done reaches 3.
- Reset mid-RUN at cycle 200 → no further writes and no out_valid. The next frame completes with correct results and frames_done=1.
- Counter wrap: preload or force frames_done to 0xFFFF and complete one frame → frames_done=0.

Source files
------------

// File: rtl/mfcc_dct_sequencer.sv
// Control sequencer for the time-multiplexed MFCC DCT: it steps one MAC through every
// (coefficient, bin) product and writes each finished coefficient into the result file.
module mfcc_dct_sequencer #(
    parameter int N_INPUTS  = 40,
    parameter int N_OUTPUTS = 13,
    parameter int SEL_W     = $clog2(N_INPUTS),
    parameter int ADDR_W    = $clog2(N_INPUTS * N_OUTPUTS),
    parameter int OADDR_W   = $clog2(N_OUTPUTS),
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic               frame_load_o,
    output logic [SEL_W-1:0]   mac_sel_o,
    output logic [ADDR_W-1:0]  rom_addr_o,
    output logic               acc_en_o,
    output logic               acc_clr_o,
    output logic               out_wr_en_o,
    output logic [OADDR_W-1:0] out_wr_addr_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic [CNT_W-1:0]   frames_done_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FLUSH,
        DONE
    } state_e;

    localparam logic [SEL_W-1:0]   J_LAST = SEL_W'(N_INPUTS - 1);
    localparam logic [OADDR_W-1:0] I_LAST = OADDR_W'(N_OUTPUTS - 1);

    state_e              state_q;
    logic [SEL_W-1:0]    j_q;
    logic [OADDR_W-1:0]  i_q;
    logic [ADDR_W-1:0]   rom_q;
    logic                wr_en_q;
    logic [OADDR_W-1:0]  wr_addr_q;
    logic [CNT_W-1:0]    frames_q;

    logic j_last;
    logic i_last;

    assign j_last = (j_q == J_LAST);
    assign i_last = (i_q == I_LAST);

    // NOTE: every register here, including the counters, sits on the async reset so an
    // aborted frame leaves no partial write or stale address behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            j_q       <= '0;
            i_q       <= '0;
            rom_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            frames_q  <= '0;
        end else begin
            // NOTE: non-blocking throughout; the default below is overridden by later
            // assignments in the same cycle, giving a one-cycle write strobe.
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid_i) state_q <= LOAD;
                end
                LOAD: begin
                    j_q     <= '0;
                    i_q     <= '0;
                    rom_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    if (j_last) begin
                        // Coefficient i is complete; its write overlaps term (i+1, 0).
                        j_q       <= '0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= i_q;
                        if (i_last) begin
                            rom_q   <= '0;
                            state_q <= FLUSH;
                        end else begin
                            i_q   <= i_q + 1'b1;
                            rom_q <= rom_q + 1'b1;
                        end
                    end else begin
                        j_q   <= j_q + 1'b1;
                        rom_q <= rom_q + 1'b1;
                    end
                end
                FLUSH: begin
                    frames_q <= frames_q + 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (out_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Remaining outputs decode straight from state and counter registers.
    assign in_ready_o    = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign frame_load_o  = (state_q == LOAD);
    assign acc_en_o      = (state_q == RUN);
    assign acc_clr_o     = (state_q == RUN) && (j_q == '0);
    assign out_valid_o   = (state_q == DONE);
    assign mac_sel_o     = j_q;
    assign rom_addr_o    = rom_q;
    assign out_wr_en_o   = wr_en_q;
    assign out_wr_addr_o = wr_addr_q;
    assign frames_done_o = frames_q;

endmodule

// File: tb/tb_mfcc_dct_sequencer.sv
// Self-checking bench: cycle-indexed reference model, key-cycle vector table, datapath
// model with a cosine ROM, and a small-parameter instance for the counter wrap.
module tb_mfcc_dct_sequencer;

    localparam int N_IN    = 40;
    localparam int N_OUT   = 13;
    localparam int N_TERMS = N_IN * N_OUT;
    localparam int T_DONE  = 3 + N_TERMS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, frame_load, acc_en, acc_clr;
    logic        out_wr_en, out_valid, out_ready, busy;
    logic [5:0]  mac_sel;
    logic [9:0]  rom_addr;
    logic [3:0]  out_wr_addr;
    logic [15:0] frames_done;

    mfcc_dct_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .frame_load_o(frame_load),
        .mac_sel_o(mac_sel), .rom_addr_o(rom_addr), .acc_en_o(acc_en), .acc_clr_o(acc_clr),
        .out_wr_en_o(out_wr_en), .out_wr_addr_o(out_wr_addr), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .busy_o(busy), .frames_done_o(frames_done)
    );

    logic       s_in_valid, s_in_ready, s_frame_load, s_acc_en, s_acc_clr;
    logic       s_out_wr_en, s_out_valid, s_out_ready, s_busy;
    logic [1:0] s_mac_sel;
    logic [3:0] s_rom_addr;
    logic [1:0] s_out_wr_addr;
    logic [1:0] s_frames_done;

    mfcc_dct_sequencer #(.N_INPUTS(4), .N_OUTPUTS(3), .CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .frame_load_o(s_frame_load),
        .mac_sel_o(s_mac_sel), .rom_addr_o(s_rom_addr), .acc_en_o(s_acc_en),
        .acc_clr_o(s_acc_clr), .out_wr_en_o(s_out_wr_en), .out_wr_addr_o(s_out_wr_addr),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .busy_o(s_busy),
        .frames_done_o(s_frames_done)
    );

    typedef struct packed {
        logic       in_ready;
        logic       busy;
        logic       frame_load;
        logic       acc_en;
        logic       acc_clr;
        logic       out_wr_en;
        logic       out_valid;
        logic [3:0] wr_addr;
        logic [5:0] mac_sel;
        logic [9:0] rom_addr;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   frames_exp = 0;
    int   cyc_abs = 0;
    int   accept_cyc = 0;
    vec_t tbl[13];
    obs_t reset_vec;

    // Datapath model: frame capture, accumulator and 13-entry result file.
    int               rom[N_TERMS];
    int               x_in[N_IN];
    int               x_cap[N_IN];
    logic signed [17:0] acc = '0;
    logic signed [17:0] rf[N_OUT];

    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    always @(posedge clk) begin
        if (frame_load) x_cap <= x_in;
        if (acc_en && mac_sel < N_IN && rom_addr < N_TERMS)
            acc <= (acc_clr ? 18'sd0 : acc) + 18'(x_cap[mac_sel] * rom[rom_addr]);
        if (out_wr_en && out_wr_addr < N_OUT) rf[out_wr_addr] <= acc;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t mk(input bit ir, input bit b, input bit fl, input bit ae,
                                input bit ac, input bit we, input bit ov,
                                input int wa, input int ms, input int ra);
        obs_t o;
        o.in_ready = ir; o.busy = b; o.frame_load = fl; o.acc_en = ae; o.acc_clr = ac;
        o.out_wr_en = we; o.out_valid = ov;
        o.wr_addr = 4'(wa); o.mac_sel = 6'(ms); o.rom_addr = 10'(ra);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.in_ready = in_ready; o.busy = busy; o.frame_load = frame_load;
        o.acc_en = acc_en; o.acc_clr = acc_clr; o.out_wr_en = out_wr_en;
        o.out_valid = out_valid;
        o.wr_addr = out_wr_en ? out_wr_addr : 4'd0;
        o.mac_sel = mac_sel; o.rom_addr = rom_addr;
        return o;
    endfunction

    // Expected outputs at cycle c of a frame (cycle 0 = accept edge), from the timing rules.
    function automatic obs_t model(input int c);
        obs_t e;
        int   t;
        e = '0;
        t = c - 2;
        e.in_ready   = (c == 0);
        e.busy       = (c >= 1);
        e.frame_load = (c == 1);
        if (c >= 2 && c < 2 + N_TERMS) begin
            e.acc_en   = 1'b1;
            e.acc_clr  = (t % N_IN == 0);
            e.mac_sel  = 6'(t % N_IN);
            e.rom_addr = 10'(t);
        end
        if (c >= 2 + N_IN && c <= 2 + N_TERMS && (t % N_IN) == 0) begin
            e.out_wr_en = 1'b1;
            e.wr_addr   = 4'(t / N_IN - 1);
        end
        e.out_valid = (c >= T_DONE);
        return e;
    endfunction

    task automatic check_tbl(input int c, input obs_t o);
        foreach (tbl[v])
            if (tbl[v].cyc == c) check($sformatf("table cycle %0d", c), 64'(o), 64'(tbl[v].exp));
    endtask

    task automatic do_frame(input int d, input bit b2b, input bit use_tbl, input int abort_at);
        int   k;
        int   gold[N_OUT];
        obs_t o;
        k = 0;
        while (!in_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("accept within bound", 64'(k < 2000), 64'(1));
        if (k >= 2000) return;
        accept_cyc = cyc_abs;
        foreach (x_in[j]) x_in[j] = int'($urandom_range(0, 6)) - 3;
        for (int i = 0; i < N_OUT; i++) begin
            gold[i] = 0;
            for (int j = 0; j < N_IN; j++) gold[i] += x_in[j] * rom[i * N_IN + j];
        end
        for (int c = 0; c <= T_DONE + d; c++) begin
            in_valid  = (c == 0 || b2b) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = (c >= T_DONE + d) ? 1'b1 :
                        (c >= T_DONE) ? 1'b0 : 1'($urandom_range(0, 1));
            o = sample();
            check($sformatf("model cycle %0d", c), 64'(o), 64'(model(c)));
            if (use_tbl) check_tbl(c, o);
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check("async reset outputs", 64'(sample()), 64'(reset_vec));
                check("async reset frames_done", 64'(frames_done), 64'(0));
                frames_exp = 0;
                return;
            end
            @(negedge clk);
        end
        in_valid = b2b;
        o = sample();
        check("idle after done", {62'd0, o.in_ready, o.busy}, 64'b10);
        if (use_tbl) check_tbl(T_DONE + d + 1, o);
        frames_exp++;
        check("frames_done", 64'(frames_done), 64'(16'(frames_exp)));
        for (int i = 0; i < N_OUT; i++)
            check($sformatf("result[%0d]", i), {46'd0, rf[i]}, {46'd0, 18'(gold[i])});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int bad;
        int seen;
        for (int a = 0; a < N_TERMS; a++)
            rom[a] = $rtoi(511.0 * $cos(3.14159265358979 * real'((a / N_IN) * (2 * (a % N_IN) + 1))
                                        / (2.0 * N_IN)));
        reset_vec = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = '{0,   mk(1, 0, 0, 0, 0, 0, 0, 0,  0,  0)};
        tbl[1]  = '{1,   mk(0, 1, 1, 0, 0, 0, 0, 0,  0,  0)};
        tbl[2]  = '{2,   mk(0, 1, 0, 1, 1, 0, 0, 0,  0,  0)};
        tbl[3]  = '{3,   mk(0, 1, 0, 1, 0, 0, 0, 0,  1,  1)};
        tbl[4]  = '{41,  mk(0, 1, 0, 1, 0, 0, 0, 0,  39, 39)};
        tbl[5]  = '{42,  mk(0, 1, 0, 1, 1, 1, 0, 0,  0,  40)};
        tbl[6]  = '{43,  mk(0, 1, 0, 1, 0, 0, 0, 0,  1,  41)};
        tbl[7]  = '{482, mk(0, 1, 0, 1, 1, 1, 0, 11, 0,  480)};
        tbl[8]  = '{521, mk(0, 1, 0, 1, 0, 0, 0, 0,  39, 519)};
        tbl[9]  = '{522, mk(0, 1, 0, 0, 0, 1, 0, 12, 0,  0)};
        tbl[10] = '{523, mk(0, 1, 0, 0, 0, 0, 1, 0,  0,  0)};
        tbl[11] = '{524, mk(1, 0, 0, 0, 0, 0, 0, 0,  0,  0)};
        tbl[12] = '{82,  mk(0, 1, 0, 1, 1, 1, 0, 1,  0,  80)};

        in_valid = 1'b0; out_ready = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset held outputs", 64'(sample()), 64'(reset_vec));
        rst_n = 1'b1;
        @(negedge clk);
        check("reset released outputs", 64'(sample()), 64'(reset_vec));
        check("reset frames_done", 64'(frames_done), 64'(0));

        do_frame(0, 1'b0, 1'b1, -1);
        do_frame(50, 1'b0, 1'b0, -1);

        do_frame(0, 1'b0, 1'b0, 200);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hold after abort", 64'(sample()), 64'(reset_vec));
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (out_wr_en || out_valid || !in_ready) bad++;
        end
        check("no activity after abort", 64'(bad), 64'(0));
        do_frame(0, 1'b0, 1'b0, -1);

        do_frame(0, 1'b1, 1'b0, -1);
        t0 = accept_cyc;
        do_frame(0, 1'b1, 1'b0, -1);
        check("back-to-back gap 1", 64'(accept_cyc - t0), 64'(524));
        t0 = accept_cyc;
        do_frame(0, 1'b1, 1'b0, -1);
        check("back-to-back gap 2", 64'(accept_cyc - t0), 64'(524));
        in_valid = 1'b0;

        s_in_valid = 1'b1; s_out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 200 && seen < 5; c++) begin
            @(negedge clk);
            if (s_out_valid) begin
                seen++;
                check($sformatf("small frames_done #%0d", seen), 64'(s_frames_done),
                      64'(seen % 4));
            end
        end
        check("small frames completed", 64'(seen), 64'(5));
        s_in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
